scp_seq_ctrl: RTL and testbench

Sequencing controller for the three-button (green/yellow/red) unlock game. It converts raw button levels into single press events and checks them against a fixed three-step code under a per-step timeout. It drives the stage flags a1..a3, flags cheating, and enforces a lockout after any failure. It sits between the debounced button synchronisers and the stage/LED display logic.

---
 rtl/scp_seq_ctrl_pkg.sv | 68 ++++++
 rtl/scp_seq_ctrl_if.sv | 28 ++
 rtl/scp_seq_ctrl_btn_edge.sv | 51 +++++
 rtl/scp_seq_ctrl.sv | 109 ++++++++++
 tb/tb_scp_seq_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/scp_seq_ctrl_pkg.sv
// Shared types for the three-button unlock sequencer: FSM states, button
// codes, the press descriptor and the registered output bundle.
package scp_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STG1  = 3'd1,
    ST_STG2  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAIL  = 3'd4,
    ST_CHEAT = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    BTN_NONE = 2'd0,
    BTN_G    = 2'd1,
    BTN_Y    = 2'd2,
    BTN_R    = 2'd3
  } btn_code_t;

  // code is BTN_NONE whenever multi is set
  typedef struct packed {
    logic      multi;
    btn_code_t code;
  } press_t;

  typedef struct packed {
    logic       a1;
    logic       a2;
    logic       a3;
    logic       cheat;
    logic       fail;
    logic       timeout;
    logic [1:0] stage;
  } out_t;

  localparam btn_code_t DEF_SEQ0 = BTN_G;
  localparam btn_code_t DEF_SEQ1 = BTN_Y;
  localparam btn_code_t DEF_SEQ2 = BTN_G;

  function automatic out_t decode_out(input state_t s, input logic tmo);
    out_t o;
    o         = '0;
    o.timeout = tmo;
    case (s)
      ST_STG1: begin
        o.a1    = 1'b1;
        o.stage = 2'd1;
      end
      ST_STG2: begin
        o.a1    = 1'b1;
        o.a2    = 1'b1;
        o.stage = 2'd2;
      end
      ST_DONE: begin
        o.a1    = 1'b1;
        o.a2    = 1'b1;
        o.a3    = 1'b1;
        o.stage = 2'd3;
      end
      ST_FAIL:  o.fail  = 1'b1;
      ST_CHEAT: o.cheat = 1'b1;
      default:  o       = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/scp_seq_ctrl_if.sv
// Button levels in, stage/status flags out, plus the FSM state for observation.
// No handshake: buttons are plain levels sampled on every rising clock edge and
// every output is a registered level that is valid from the edge that sets it.
interface scp_seq_ctrl_if;
  import scp_seq_ctrl_pkg::*;

  logic       g;
  logic       y;
  logic       r;
  logic       a1;
  logic       a2;
  logic       a3;
  logic       cheat_out;
  logic       fail;
  logic       timeout;
  logic [1:0] stage;
  state_t     dbg_state;

  modport master (
    output g, y, r,
    input  a1, a2, a3, cheat_out, fail, timeout, stage, dbg_state
  );

  modport slave (
    input  g, y, r,
    output a1, a2, a3, cheat_out, fail, timeout, stage, dbg_state
  );
endinterface

// File: rtl/scp_seq_ctrl_btn_edge.sv
// Rising-edge press detector for the three buttons, encoding one press per
// cycle into a code and flagging simultaneous presses as MULTI.
module scp_seq_ctrl_btn_edge
  import scp_seq_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_g,
  input  logic   i_y,
  input  logic   i_r,
  output press_t o_press
);

  logic       r_prev_g;
  logic       r_prev_y;
  logic       r_prev_r;
  logic       w_press_g;
  logic       w_press_y;
  logic       w_press_r;
  logic [1:0] w_cnt;

  // Reset to 1 so a button held across reset release is not seen as a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_g <= 1'b1;
      r_prev_y <= 1'b1;
      r_prev_r <= 1'b1;
    end else begin
      r_prev_g <= i_g;
      r_prev_y <= i_y;
      r_prev_r <= i_r;
    end
  end

  assign w_press_g = i_g & ~r_prev_g;
  assign w_press_y = i_y & ~r_prev_y;
  assign w_press_r = i_r & ~r_prev_r;
  assign w_cnt     = {1'b0, w_press_g} + {1'b0, w_press_y} + {1'b0, w_press_r};

  always_comb begin
    o_press       = '0;
    o_press.multi = (w_cnt > 2'd1);
    if (!o_press.multi) begin
      if (w_press_g)      o_press.code = BTN_G;
      else if (w_press_y) o_press.code = BTN_Y;
      else if (w_press_r) o_press.code = BTN_R;
      else                o_press.code = BTN_NONE;
    end
  end

endmodule

// File: rtl/scp_seq_ctrl.sv
// Unlock-game sequencer: matches three button presses against a fixed code
// under a per-step timeout, with a fixed lockout after any failure or cheat.
module scp_seq_ctrl
  import scp_seq_ctrl_pkg::*;
#(
  parameter int        TIMEOUT_CYC = 50,
  parameter int        LOCKOUT_CYC = 20,
  parameter int        CNT_W       = 8,
  parameter btn_code_t SEQ0        = DEF_SEQ0,
  parameter btn_code_t SEQ1        = DEF_SEQ1,
  parameter btn_code_t SEQ2        = DEF_SEQ2
) (
  input logic          clk,
  input logic          rst_n,
  scp_seq_ctrl_if.slave bus
);

  press_t           w_press;
  logic             w_any;
  logic             w_tmo_hit;
  logic             w_lock_hit;
  logic             w_counting;
  logic             w_expire;
  state_t           w_next;
  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  out_t             r_out;

  scp_seq_ctrl_btn_edge u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_g     (bus.g),
    .i_y     (bus.y),
    .i_r     (bus.r),
    .o_press (w_press)
  );

  // MULTI is judged before the code match so two buttons at once never count.
  function automatic state_t step_next(input press_t p, input btn_code_t want,
                                       input state_t on_match);
    if (p.multi)            return ST_CHEAT;
    else if (p.code == want) return on_match;
    else if (p.code == BTN_R) return ST_CHEAT;
    else                    return ST_FAIL;
  endfunction

  assign w_any      = w_press.multi || (w_press.code != BTN_NONE);
  assign w_tmo_hit  = (r_timer == CNT_W'(TIMEOUT_CYC - 1));
  assign w_lock_hit = (r_timer == CNT_W'(LOCKOUT_CYC - 1));
  assign w_counting = (r_state == ST_STG1) || (r_state == ST_STG2) ||
                      (r_state == ST_FAIL) || (r_state == ST_CHEAT);

  always_comb begin
    w_next   = r_state;
    w_expire = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_next = step_next(w_press, SEQ0, ST_STG1);
      end
      ST_STG1: begin
        if (w_any) begin
          w_next = step_next(w_press, SEQ1, ST_STG2);
        end else if (w_tmo_hit) begin
          w_next   = ST_FAIL;
          w_expire = 1'b1;
        end
      end
      ST_STG2: begin
        if (w_any) begin
          w_next = step_next(w_press, SEQ2, ST_DONE);
        end else if (w_tmo_hit) begin
          w_next   = ST_FAIL;
          w_expire = 1'b1;
        end
      end
      ST_DONE: begin
        if (!w_press.multi && (w_press.code == BTN_R)) w_next = ST_IDLE;
      end
      ST_FAIL, ST_CHEAT: begin
        if (w_lock_hit) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || !w_counting) r_timer <= '0;
      else                                    r_timer <= r_timer + 1'b1;
      r_out   <= decode_out(w_next, w_expire);
    end
  end

  assign bus.a1        = r_out.a1;
  assign bus.a2        = r_out.a2;
  assign bus.a3        = r_out.a3;
  assign bus.cheat_out = r_out.cheat;
  assign bus.fail      = r_out.fail;
  assign bus.timeout   = r_out.timeout;
  assign bus.stage     = r_out.stage;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_scp_seq_ctrl.sv
// Bench for scp_seq_ctrl: directed scenarios plus random button activity,
// checked cycle by cycle against a countdown-based model of the game rules.
module tb_scp_seq_ctrl;
  import scp_seq_ctrl_pkg::*;

  localparam int TIMEOUT = 50;
  localparam int LOCKOUT = 20;
  localparam int W       = 11;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc_no;
  logic [W-1:0] exp_q[$];

  scp_seq_ctrl_if bus ();

  scp_seq_ctrl #(
    .TIMEOUT_CYC (TIMEOUT),
    .LOCKOUT_CYC (LOCKOUT),
    .CNT_W       (8),
    .SEQ0        (BTN_G),
    .SEQ1        (BTN_Y),
    .SEQ2        (BTN_G)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst_n  = 1'b0;
    bus.g  = 1'b0;
    bus.y  = 1'b0;
    bus.r  = 1'b0;
  end

  // reference model: steps achieved, lockout cycles left, cycles left in step
  int m_step;
  int m_lock;
  bit m_cheat;
  int m_left;
  bit m_pg, m_py, m_pr;
  int seq[3];
  initial seq = '{1, 2, 1};

  task automatic lock_enter(input bit c);
    m_lock  = LOCKOUT;
    m_cheat = c;
    m_step  = 0;
  endtask

  task automatic model_edge(input bit g, input bit y, input bit r, input bit rn,
                            output logic [W-1:0] e);
    bit       pg, py, pr, tmo;
    int       n, pcode;
    logic [2:0] st;
    logic [1:0] stg;
    tmo = 1'b0;
    if (!rn) begin
      m_step = 0;
      m_lock = 0;
      m_left = 0;
      m_pg = 1'b1; m_py = 1'b1; m_pr = 1'b1;
    end else begin
      pg = g && !m_pg;
      py = y && !m_py;
      pr = r && !m_pr;
      m_pg = g; m_py = y; m_pr = r;
      n     = int'(pg) + int'(py) + int'(pr);
      pcode = pg ? 1 : (py ? 2 : (pr ? 3 : 0));
      if (m_lock > 0) begin
        m_lock--;
      end else if (m_step == 3) begin
        if (n == 1 && pr) m_step = 0;
      end else if (n >= 2 || (n == 1 && pr)) begin
        lock_enter(1'b1);
      end else if (n == 1) begin
        if (pcode == seq[m_step]) begin
          m_step++;
          m_left = TIMEOUT;
        end else begin
          lock_enter(1'b0);
        end
      end else if (m_step > 0) begin
        m_left--;
        if (m_left == 0) begin
          tmo = 1'b1;
          lock_enter(1'b0);
        end
      end
    end
    if (m_lock > 0) begin
      st  = m_cheat ? 3'(ST_CHEAT) : 3'(ST_FAIL);
      stg = 2'd0;
    end else begin
      case (m_step)
        0:       st = 3'(ST_IDLE);
        1:       st = 3'(ST_STG1);
        2:       st = 3'(ST_STG2);
        default: st = 3'(ST_DONE);
      endcase
      stg = 2'(m_step);
    end
    e = {st, stg, (m_lock == 0 && m_step >= 1), (m_lock == 0 && m_step >= 2),
         (m_lock == 0 && m_step == 3), (m_lock > 0 && m_cheat),
         (m_lock > 0 && !m_cheat), tmo};
  endtask

  // driver tasks
  task automatic cyc(input bit g, input bit y, input bit r, input bit rn);
    logic [W-1:0] e;
    @(negedge clk);
    bus.g = g;
    bus.y = y;
    bus.r = r;
    rst_n = rn;
    model_edge(g, y, r, rn, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic press(input int b);
    cyc(b == 1, b == 2, b == 3, 1'b1);
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    cyc_no = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {3'(bus.dbg_state), bus.stage, bus.a1, bus.a2, bus.a3,
               bus.cheat_out, bus.fail, bus.timeout};
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL out_vec cycle=%0d act=%b exp=%b (state,stage,a1,a2,a3,cheat,fail,timeout)",
                   cyc_no, act, e);
        end
      end
    end
  end

  // stimulus
  initial begin
    int gap;
    int b;
    bit lg, ly, lr;
    checks   = 0;
    failures = 0;

    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // full code with 5-cycle spacing, then R from DONE
    press(1); idle(4); press(2); idle(4); press(1); idle(3);
    press(1); idle(1); press(3); idle(3);

    // single step then timeout and lockout
    press(1); idle(TIMEOUT + LOCKOUT + 3);

    // R in IDLE -> cheat, G during lockout ignored
    press(3); idle(5); press(1); idle(LOCKOUT);

    // G+Y together in STG1
    press(1); idle(2); cyc(1'b1, 1'b1, 1'b0, 1'b1); idle(LOCKOUT + 2);

    // g held through reset release
    cyc(1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    idle(1); press(1); idle(2);
    press(3); idle(LOCKOUT + 2);

    // press exactly on the expiry cycle of STG2
    press(1); idle(1); press(2); idle(TIMEOUT - 1); press(1); idle(2);
    press(3); idle(2);

    // one cycle too late
    press(1); idle(1); press(2); idle(TIMEOUT); press(1); idle(LOCKOUT + 2);

    // reset mid-STG2
    press(1); idle(1); press(2); idle(3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0); idle(3);

    // random attempts at the code with random gaps and occasional wrong buttons
    repeat (10) begin
      for (int s = 0; s < 3; s++) begin
        gap = $urandom_range(0, 55);
        idle(gap + 1);
        b = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : seq[s];
        press(b);
      end
      idle($urandom_range(1, 4));
      press(3);
      idle(LOCKOUT + 2);
    end

    // random button levels with sporadic reset
    lg = 1'b0; ly = 1'b0; lr = 1'b0;
    repeat (600) begin
      if ($urandom_range(0, 5) == 0) lg = ~lg;
      if ($urandom_range(0, 5) == 0) ly = ~ly;
      if ($urandom_range(0, 7) == 0) lr = ~lr;
      cyc(lg, ly, lr, ($urandom_range(0, 199) != 0));
    end
    idle(2);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain act=%0d left exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
